// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing constants, SFR map and decode helpers for the LED transmitter and receiver.
package ws2812_pkg;

    localparam int unsigned T0H      = 20;
    localparam int unsigned T1H      = 40;
    localparam int unsigned T_THRESH = 30;
    localparam int unsigned RESET    = 3000;

    localparam logic [7:0] SFR_TX_CTRL = 8'hC2;
    localparam logic [7:0] SFR_TX_G    = 8'hC3;
    localparam logic [7:0] SFR_TX_R    = 8'hC4;
    localparam logic [7:0] SFR_TX_B    = 8'hC5;
    localparam logic [7:0] SFR_RX_STAT = 8'hC6;
    localparam logic [7:0] SFR_RX_DATA = 8'hC7;
    localparam logic [7:0] SFR_RX_FLEN = 8'hC8;

    typedef enum logic [1:0] {ByteG, ByteR, ByteB} byte_sel_e;
    typedef enum logic [1:0] {PulseGlitch, PulseZero, PulseOne, PulseErr} pulse_e;

    function automatic pulse_e classify_pulse(input int unsigned width, input int unsigned glitch,
                                              input int unsigned thresh,
                                              input int unsigned high_max);
        if (width < glitch) return PulseGlitch;
        if (width <= thresh) return PulseZero;
        if (width <= high_max) return PulseOne;
        return PulseErr;
    endfunction

endpackage

// File: rtl/ws2812_rx_fifo.sv
// Synchronous word FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module ws2812_rx_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wrap_inc(wr_ptr_q);
            if (do_pop) rd_ptr_q <= wrap_inc(rd_ptr_q);
            if (do_push && !do_pop) count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: pulse-width decoder, frame detection and 8051 SFR access to a word FIFO.
module ws2812_rx #(
    parameter int unsigned T_GLITCH   = 8,
    parameter int unsigned T_THRESH   = ws2812_pkg::T_THRESH,
    parameter int unsigned T_HIGH_MAX = 60,
    parameter int unsigned RESET      = ws2812_pkg::RESET,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic [7:0] sfr_addr,
    input  logic       sfr_rd,
    input  logic       sfr_wr,
    input  logic [7:0] controller_data_in,
    output logic [7:0] sfr_data_out,
    output logic       irq
);
    import ws2812_pkg::*;

    localparam int unsigned HW = $clog2(T_HIGH_MAX + 2);
    localparam int unsigned LW = $clog2(RESET + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic          din_meta_q, din_sync_q, din_prev_q;
    logic [HW-1:0] high_cnt_q, high_cnt_d;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    word_cnt_q, word_cnt_d, frame_len_q, frame_len_d;
    logic          ovf_q, err_q, done_q, enable_q;
    logic          ovf_d, err_d, done_d, enable_d;
    byte_sel_e     ptr_q, ptr_d;
    logic [7:0]    rd_data_d;
    logic          fall, frame_end, word_push, err_set, wr_stat;
    pulse_e        pulse;
    logic          fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [23:0]   fifo_head;

    ws2812_rx_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .push  (word_push),
        .wdata (shift_d),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fall    = din_prev_q & ~din_sync_q;
    assign pulse   = classify_pulse(32'(high_cnt_q), T_GLITCH, T_THRESH, T_HIGH_MAX);
    assign wr_stat = sfr_wr && (sfr_addr == SFR_RX_STAT);

    always_comb begin
        high_cnt_d = '0;
        if (din_sync_q) begin
            high_cnt_d = (high_cnt_q == HW'(T_HIGH_MAX + 1)) ? high_cnt_q : high_cnt_q + HW'(1);
        end
        low_cnt_d = '0;
        frame_end = 1'b0;
        if (!din_sync_q) begin
            low_cnt_d = low_cnt_q;
            if (low_cnt_q != LW'(RESET)) begin
                low_cnt_d = low_cnt_q + LW'(1);
                frame_end = (low_cnt_q == LW'(RESET - 1));
            end
        end

        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        word_push = 1'b0;
        err_set   = 1'b0;
        if (!enable_q) begin
            bit_cnt_d = '0;
        end else if (fall) begin
            case (pulse)
                PulseZero, PulseOne: begin
                    shift_d = {shift_q[22:0], pulse == PulseOne};
                    if (bit_cnt_q == 5'd23) begin
                        word_push = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                PulseErr: begin
                    err_set   = 1'b1;
                    bit_cnt_d = '0;
                end
                default: ;
            endcase
        end
        // A frame that ends mid-word leaves an unusable partial word behind.
        if (frame_end && bit_cnt_q != '0) begin
            err_set   = 1'b1;
            bit_cnt_d = '0;
        end

        word_cnt_d  = word_cnt_q;
        frame_len_d = frame_len_q;
        if (frame_end) begin
            frame_len_d = word_cnt_q;
            word_cnt_d  = '0;
        end else if (word_push && word_cnt_q != 8'hFF) begin
            word_cnt_d = word_cnt_q + 8'd1;
        end
    end

    always_comb begin
        rd_data_d  = sfr_data_out;
        ptr_d      = ptr_q;
        fifo_pop   = 1'b0;
        if (sfr_rd) begin
            case (sfr_addr)
                SFR_RX_STAT: rd_data_d = {3'(fifo_count), done_q, err_q, ovf_q, fifo_full,
                                          ~fifo_empty};
                SFR_RX_DATA: begin
                    rd_data_d = 8'h00;
                    if (!fifo_empty) begin
                        case (ptr_q)
                            ByteG: begin
                                rd_data_d = fifo_head[23:16];
                                ptr_d     = ByteR;
                            end
                            ByteR: begin
                                rd_data_d = fifo_head[15:8];
                                ptr_d     = ByteB;
                            end
                            default: begin
                                rd_data_d = fifo_head[7:0];
                                ptr_d     = ByteG;
                                fifo_pop  = 1'b1;
                            end
                        endcase
                    end
                end
                SFR_RX_FLEN: rd_data_d = frame_len_q;
                default:     rd_data_d = 8'h00;
            endcase
        end
        fifo_flush = wr_stat & controller_data_in[7];
        if (fifo_flush) ptr_d = ByteG;

        // Setting wins over a write-one-to-clear in the same cycle.
        ovf_d    = (ovf_q & ~(wr_stat & controller_data_in[2])) |
                   (word_push & fifo_full & ~fifo_pop);
        err_d    = (err_q & ~(wr_stat & controller_data_in[3])) | err_set;
        done_d   = (done_q & ~(wr_stat & controller_data_in[4])) | frame_end;
        enable_d = (sfr_wr && sfr_addr == SFR_RX_FLEN) ? controller_data_in[0] : enable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_meta_q   <= 1'b0;
            din_sync_q   <= 1'b0;
            din_prev_q   <= 1'b0;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            frame_len_q  <= '0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            enable_q     <= 1'b1;
            ptr_q        <= ByteG;
            sfr_data_out <= '0;
            irq          <= 1'b0;
        end else begin
            din_meta_q   <= din;
            din_sync_q   <= din_meta_q;
            din_prev_q   <= din_sync_q;
            high_cnt_q   <= high_cnt_d;
            low_cnt_q    <= low_cnt_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            frame_len_q  <= frame_len_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            done_q       <= done_d;
            enable_q     <= enable_d;
            ptr_q        <= ptr_d;
            sfr_data_out <= rd_data_d;
            irq          <= ~fifo_empty | done_q;
        end
    end

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 SHALL have parameter T_GLITCH, default 8, meaning high pulses shorter than this many clk cycles are ignored.
REQ-002 SHALL have parameter T_THRESH, default 30, meaning a high-pulse width of T_THRESH cycles or less decodes as 0 and a wider pulse decodes as 1.
REQ-003 SHALL have parameter T_HIGH_MAX, default 60, meaning a high-pulse width above this value is a pulse error.
REQ-004 SHALL have parameter RESET, default 3000, meaning the number of consecutive low cycles that ends a frame (60 us at 50 MHz).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of 24-bit words buffered.
REQ-006 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port din  input  1  WS2812 serial line, asynchronous to clk.
REQ-009 SHALL have port sfr_addr  input  8  8051 SFR address.
REQ-010 SHALL have port sfr_rd  input  1  SFR read strobe, one cycle.
REQ-011 SHALL have port sfr_wr  input  1  SFR write strobe, one cycle.
REQ-012 SHALL have port controller_data_in  input  8  SFR write data.
REQ-013 SHALL have port sfr_data_out  output  8  SFR read data, registered.
REQ-014 SHALL have port irq  output  1  registered; equals (FIFO not empty) OR frame_done.

Function
REQ-015 SHALL pass din through a 2-flop synchronizer; all decoding SHALL use the synchronized signal.
REQ-016 SHALL count the high width, saturating at T_HIGH_MAX+1.
REQ-017 On each falling edge SHALL classify the width: below T_GLITCH: ignored; up to T_THRESH: bit 0; above T_THRESH and up to T_HIGH_MAX: bit 1; above T_HIGH_MAX: set err and discard the partial word.
REQ-018 SHALL shift bits MSB-first into a 24-bit register with a 5-bit bit counter; on the 24th bit SHALL push the word (G[23:16], R[15:8], B[7:0]) and clear the bit counter.
REQ-019 If a push finds the FIFO full, SHALL drop the word and set ovf.
REQ-020 SHALL count low cycles, saturating at RESET; on reaching RESET SHALL set frame_done, latch the word count into frame_len, and clear the word count.
REQ-021 A nonzero bit counter at frame end SHALL set err and discard the partial bits.
REQ-022 The per-frame word count SHALL saturate at 255 and SHALL include dropped words.
REQ-023 A read of address 0xC6 SHALL return status: bit0 not empty, bit1 full, bit2 ovf, bit3 err, bit4 frame_done, bits7:5 FIFO count.
REQ-024 A read of address 0xC7 SHALL return the head-word byte selected by a byte pointer (0=G, 1=R, 2=B); reading B SHALL pop the FIFO and reset the pointer. When the FIFO is empty, the read SHALL return 0x00 with no state change.
REQ-025 A read of address 0xC8 SHALL return frame_len.
REQ-026 sfr_data_out SHALL be valid in the cycle after sfr_rd; all pop side effects SHALL occur on the sfr_rd cycle.
REQ-027 A write to address 0xC6 SHALL clear ovf, err and frame_done wherever the matching data bit is 1; data bit7=1 SHALL flush the FIFO and reset the byte pointer.
REQ-028 A write to address 0xC8 with bit0 SHALL set enable. While enable=0, edges SHALL be ignored and the decoder SHALL hold its bit counter at 0.
REQ-029 A simultaneous push and pop SHALL both occur and leave the count unchanged; a flag set and clear in the same cycle SHALL leave the flag set.

Reset
REQ-030 rst_n low SHALL clear the synchronizer, counters, FIFO, byte pointer, flags and frame_len to 0, set enable to 1, and drive sfr_data_out and irq to 0, with immediate effect even in the middle of a frame.

Structure
REQ-031 The package ws2812_pkg SHALL hold the timing constants (T0H, T1H, T_THRESH, RESET) and the SFR addresses 0xC2-0xC8, shared with the transmitter.
REQ-032 The FIFO SHALL be the sub-module ws2812_rx_fifo (synchronous, with push, pop, full, empty and count ports).

Verification
REQ-033 One word G=0xFF, R=0x00, B=0x00 (8x40/22 then 16x20/42 cycles) followed by 3000 low cycles -> status 0x31; reads of 0xC7 return FF, 00, 00; status then reads 0x10; address 0xC8 reads 1.
REQ-034 Five words in one frame with no reads -> status 0x97, frame_len=5, and the FIFO holds the first four words.
REQ-035 An 80-cycle high pulse at bit 5 -> err set, no push; the next 24 valid bits push exactly one word.
REQ-036 A 3-cycle high glitch inside the low phase of bit 10 -> ignored; the word decodes correctly with err=0.
REQ-037 12 bits then 3000 low cycles -> err=1, frame_done=1, FIFO empty, frame_len=0.
REQ-038 rst_n pulsed low at bit 10 of a frame -> status 0x00 and irq=0 immediately; the next full word decodes correctly.
